// File: rtl/char_buffer_ram.sv
// ============================================================================
//  Module   : char_buffer_ram
//  Purpose  : ROWS x COLS character buffer with self-clear, one write port,
//             a registered read port and two fixed registered taps.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module char_buffer_ram #(
  parameter int                DATA_W      = 8,
  parameter int                ROWS        = 32,
  parameter int                COLS        = 4,
  parameter logic [DATA_W-1:0] FILL        = '0,
  parameter bit                FILTER_CTRL = 1'b1,
  parameter int                TAP0_ADDR   = 0,
  parameter int                TAP1_ADDR   = 1,
  localparam int               N           = ROWS * COLS,
  localparam int               RW          = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int               CW          = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              we,
  input  logic [RW-1:0]     w_row,
  input  logic [CW-1:0]     w_col,
  input  logic [DATA_W-1:0] din,
  input  logic [RW-1:0]     r_row,
  input  logic [CW-1:0]     r_col,
  output logic [DATA_W-1:0] dout,
  output logic [DATA_W-1:0] tdout0,
  output logic [DATA_W-1:0] tdout1,
  output logic              busy,
  output logic              done
);

  localparam int AW = $clog2(N) + 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  localparam logic [IW-1:0] TAP0_I = IW'(TAP0_ADDR);
  localparam logic [IW-1:0] TAP1_I = IW'(TAP1_ADDR);
  localparam logic [IW-1:0] LAST_I = IW'(N - 1);

  logic [DATA_W-1:0] mem_q [N];

  logic [0:0]        state_q,  state_d;
  logic [IW-1:0]     cursor_q, cursor_d;
  logic              done_q,   done_d;
  logic [DATA_W-1:0] dout_q,   dout_d;
  logic [DATA_W-1:0] tdout0_q, tdout0_d;
  logic [DATA_W-1:0] tdout1_q, tdout1_d;

  logic              mem_we;
  logic [IW-1:0]     mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic [AW-1:0]     w_flat;
  logic [AW-1:0]     r_flat;
  logic              w_in_range;
  logic              r_in_range;
  logic              w_is_ctrl;

  // Flat indices are one bit wider than needed so row*COLS+col never wraps.
  assign w_flat = AW'(w_row) * AW'(COLS) + AW'(w_col);
  assign r_flat = AW'(r_row) * AW'(COLS) + AW'(r_col);

  assign w_in_range = (AW'(w_row) < AW'(ROWS)) && (AW'(w_col) < AW'(COLS)) &&
                      (w_flat < AW'(N));
  assign r_in_range = (AW'(r_row) < AW'(ROWS)) && (AW'(r_col) < AW'(COLS)) &&
                      (r_flat < AW'(N));

  generate
    if (FILTER_CTRL) begin : g_filter
      assign w_is_ctrl = (din[7:0] == 8'h0D) || (din[7:0] == 8'h0A);
    end else begin : g_no_filter
      assign w_is_ctrl = 1'b0;
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    cursor_d  = cursor_q;
    done_d    = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = cursor_q;
    mem_wdata = FILL;
    dout_d    = r_in_range ? mem_q[r_flat[IW-1:0]] : FILL;
    tdout0_d  = mem_q[TAP0_I];
    tdout1_d  = mem_q[TAP1_I];

    if (reset) begin
      state_d  = S_CLEAR;
      cursor_d = '0;
      dout_d   = '0;
      tdout0_d = '0;
      tdout1_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (clr) begin
            state_d  = S_CLEAR;
            cursor_d = '0;
          end else if (we && w_in_range && !w_is_ctrl) begin
            mem_we    = 1'b1;
            mem_waddr = w_flat[IW-1:0];
            mem_wdata = din;
          end
        end
        S_CLEAR: begin
          mem_we = 1'b1;
          if (cursor_q == LAST_I) begin
            state_d  = S_IDLE;
            cursor_d = '0;
            done_d   = 1'b1;
          end else begin
            cursor_d = cursor_q + IW'(1);
          end
        end
        default: begin
          state_d  = S_CLEAR;
          cursor_d = '0;
        end
      endcase
    end
  end

  // Array has no reset of its own; the clear sequence initialises it.
  always_ff @(posedge clk) begin
    state_q  <= state_d;
    cursor_q <= cursor_d;
    done_q   <= done_d;
    dout_q   <= dout_d;
    tdout0_q <= tdout0_d;
    tdout1_q <= tdout1_d;
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign dout   = dout_q;
  assign tdout0 = tdout0_q;
  assign tdout1 = tdout1_q;
  assign busy   = (state_q == S_CLEAR);
  assign done   = done_q;

endmodule

`default_nettype wire

// File: tb/tb_char_buffer_ram.sv
// ============================================================================
//  Module   : tb_char_buffer_ram
//  Purpose  : Scoreboard bench for char_buffer_ram (filtered 32x4 instance
//             plus unfiltered 3x3 instance with non-power-of-two geometry).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_char_buffer_ram;

  localparam int K_DOUT1 = 0;
  localparam int K_T0_1  = 1;
  localparam int K_T1_1  = 2;
  localparam int K_DOUT2 = 3;
  localparam int K_T0_2  = 4;
  localparam int K_T1_2  = 5;
  localparam int K_DONE1 = 6;

  logic       clk = 1'b0;
  logic       reset, clr, we;
  logic [4:0] w_row, r_row;
  logic [1:0] w_col, r_col;
  logic [7:0] din;

  logic [7:0] dout1, t0_1, t1_1, dout2, t0_2, t1_2;
  logic       busy1, done1, busy2, done2;

  always #5 clk = ~clk;

  char_buffer_ram #(
    .DATA_W(8), .ROWS(32), .COLS(4), .FILL(8'h20), .FILTER_CTRL(1'b1),
    .TAP0_ADDR(0), .TAP1_ADDR(1)
  ) u_dut1 (
    .clk(clk), .reset(reset), .clr(clr), .we(we),
    .w_row(w_row), .w_col(w_col), .din(din),
    .r_row(r_row), .r_col(r_col),
    .dout(dout1), .tdout0(t0_1), .tdout1(t1_1),
    .busy(busy1), .done(done1)
  );

  char_buffer_ram #(
    .DATA_W(8), .ROWS(3), .COLS(3), .FILL(8'hEE), .FILTER_CTRL(1'b0),
    .TAP0_ADDR(0), .TAP1_ADDR(8)
  ) u_dut2 (
    .clk(clk), .reset(reset), .clr(clr), .we(we),
    .w_row(w_row[1:0]), .w_col(w_col), .din(din),
    .r_row(r_row[1:0]), .r_col(r_col),
    .dout(dout2), .tdout0(t0_2), .tdout1(t1_2),
    .busy(busy2), .done(done2)
  );

  typedef struct {
    int         cyc;
    int         kind;
    logic [7:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   total   = 0;
  int   bad     = 0;
  int   cyc_cnt = 0;
  int   done1_n = 0;
  int   done2_n = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    if (done1 === 1'b1) done1_n++;
    if (done2 === 1'b1) done2_n++;
  end

  function automatic logic [7:0] act_of(input int k);
    case (k)
      K_DOUT1: return dout1;
      K_T0_1:  return t0_1;
      K_T1_1:  return t1_1;
      K_DOUT2: return dout2;
      K_T0_2:  return t0_2;
      K_T1_2:  return t1_2;
      default: return {7'b0, done1};
    endcase
  endfunction

  function automatic string kname(input int k);
    case (k)
      K_DOUT1: return "dut1.dout";
      K_T0_1:  return "dut1.tdout0";
      K_T1_1:  return "dut1.tdout1";
      K_DOUT2: return "dut2.dout";
      K_T0_2:  return "dut2.tdout0";
      K_T1_2:  return "dut2.tdout1";
      default: return "dut1.done";
    endcase
  endfunction

  // Monitor: pops every expectation that has come due at this sample point.
  always @(negedge clk) begin : mon
    exp_t e;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc_cnt) begin
      e = sbq.pop_front();
      total++;
      if (e.cyc < cyc_cnt) begin
        bad++;
        $display("FAIL sb_late %s due cycle %0d seen cycle %0d", kname(e.kind), e.cyc, cyc_cnt);
      end else if (act_of(e.kind) !== e.exp) begin
        bad++;
        $display("FAIL %s cycle=%0d actual=%h required=%h", kname(e.kind), cyc_cnt,
                 act_of(e.kind), e.exp);
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  // Expectation for the registered outputs after the coming clock edge.
  task automatic exp_push(input int k, input logic [7:0] v);
    exp_t e;
    e.cyc  = cyc_cnt + 1;
    e.kind = k;
    e.exp  = v;
    sbq.push_back(e);
  endtask

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic wr(input int row, input int col, input logic [7:0] d);
    we    = 1'b1;
    w_row = 5'(row);
    w_col = 2'(col);
    din   = d;
  endtask

  task automatic rd(input int row, input int col);
    r_row = 5'(row);
    r_col = 2'(col);
  endtask

  // Counts busy cycles of dut1; kind 1 injects writes to (5,1), kind 2 a reset.
  task automatic wait_clear(input int act_at, input int act_kind, output int n);
    n = 0;
    while (busy1 === 1'b1 && n < 2000) begin
      we    = 1'b0;
      reset = 1'b0;
      if (act_kind == 1 && (n == act_at || n == 100)) wr(5, 1, 8'h55);
      if (act_kind == 2 && n == act_at) reset = 1'b1;
      n++;
      step();
    end
    we    = 1'b0;
    reset = 1'b0;
  endtask

  task automatic check_clear(input string nm, input int n, input int req_n, input int d0);
    step();
    chk({nm, "_busy_len"}, n, req_n);
    chk({nm, "_done_cnt"}, done1_n - d0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int d0;

    reset = 1'b1; clr = 1'b0; we = 1'b0;
    w_row = '0; w_col = '0; din = '0; r_row = '0; r_col = '0;

    // Reset state and power-on clear
    exp_push(K_DOUT1, 8'h00);
    exp_push(K_T0_1,  8'h00);
    exp_push(K_T1_1,  8'h00);
    exp_push(K_DOUT2, 8'h00);
    exp_push(K_DONE1, 8'h00);
    step();
    reset = 1'b0;
    d0 = done1_n;
    wait_clear(-1, 0, n);
    check_clear("t1", n, 128, d0);
    chk("t1_dut2_busy", int'(busy2), 0);
    chk("t1_dut2_done", done2_n, 1);
    for (int r = 0; r < 32; r++) begin
      for (int c = 0; c < 4; c++) begin
        rd(r, c);
        exp_push(K_DOUT1, 8'h20);
        step();
      end
    end

    // Simple write then read
    wr(3, 2, 8'h41);
    step();
    we = 1'b0;
    rd(3, 2);
    exp_push(K_DOUT1, 8'h41);
    step();

    // Control-code filter on dut1, pass-through on dut2
    wr(0, 0, 8'h0D);
    step();
    din = 8'h0A;
    exp_push(K_T0_1, 8'h20);
    exp_push(K_T0_2, 8'h0D);
    step();
    we = 1'b0;
    exp_push(K_T0_1, 8'h20);
    exp_push(K_T0_2, 8'h0A);
    step();
    wr(0, 1, 8'h33);
    step();
    we = 1'b0;
    rd(0, 1);
    exp_push(K_T1_1,  8'h33);
    exp_push(K_DOUT1, 8'h33);
    exp_push(K_DOUT2, 8'h33);
    exp_push(K_T1_2,  8'hEE);
    step();

    // Column out of range on dut2 (would alias (1,0)); in range on dut1
    wr(0, 3, 8'h99);
    step();
    we = 1'b0;
    rd(1, 0);
    exp_push(K_DOUT1, 8'h20);
    exp_push(K_DOUT2, 8'hEE);
    step();
    rd(3, 0);
    exp_push(K_DOUT1, 8'h20);
    exp_push(K_DOUT2, 8'hEE);
    step();
    rd(0, 3);
    exp_push(K_DOUT1, 8'h99);
    exp_push(K_DOUT2, 8'hEE);
    step();

    // Writes during clear are dropped
    clr = 1'b1;
    step();
    clr = 1'b0;
    d0 = done1_n;
    wait_clear(9, 1, n);
    check_clear("t4", n, 128, d0);
    rd(5, 1);
    exp_push(K_DOUT1, 8'h20);
    step();

    // Reset restarts an ongoing clear
    wr(3, 2, 8'h41);
    step();
    we = 1'b0;
    rd(3, 2);
    reset = 1'b1;
    exp_push(K_DOUT1, 8'h00);
    step();
    reset = 1'b0;
    d0 = done1_n;
    wait_clear(60, 2, n);
    check_clear("t5", n, 189, d0);
    rd(3, 2);
    exp_push(K_DOUT1, 8'h20);
    step();

    // clr beats a same-cycle write
    clr = 1'b1;
    wr(1, 0, 8'h7A);
    step();
    clr = 1'b0;
    we  = 1'b0;
    d0 = done1_n;
    wait_clear(-1, 0, n);
    check_clear("t6", n, 128, d0);
    rd(1, 0);
    exp_push(K_DOUT1, 8'h20);
    step();

    // Read-first on the read port and on a tap
    wr(1, 0, 8'h7A);
    rd(1, 0);
    exp_push(K_DOUT1, 8'h20);
    step();
    we = 1'b0;
    exp_push(K_DOUT1, 8'h7A);
    step();
    wr(0, 0, 8'h5A);
    exp_push(K_T0_1, 8'h20);
    step();
    we = 1'b0;
    exp_push(K_T0_1, 8'h5A);
    step();

    step();
    step();
    chk("sb_drain", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
